shift_add_multiplier: RTL and testbench

//   Iterative 32x32 -> 64-bit unsigned multiplier built on shift-and-add.

---
 rtl/shift_add_multiplier.sv | 89 ++++++++
 tb/tb_shift_add_multiplier.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned multiplier: one shift-and-add step per clock through an
// external WIDTH-bit adder. It produces a 2*WIDTH-bit product after WIDTH iterations.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_c0,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  m;
  logic [CW-1:0]     count;

  // Sequencer and datapath. The adder carry-out becomes the new accumulator MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {add_cout, add_sum[WIDTH-1:1]};
          q     <= {add_sum[0], q[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == LAST) begin
            product <= {add_cout, add_sum, q[WIDTH-1:1]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Adder operands come straight from the registers. Only RUN adds M.
  assign add_a  = acc;
  assign add_b  = (state == RUN && q[0]) ? m : '0;
  assign add_c0 = 1'b0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a transaction-level model plus directed and random vectors.
// It also contains a behavioural stand-in for the external ripple-carry adder.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_c0;
  logic [31:0] add_sum;
  logic        add_cout;

  int checks = 0;
  int fails = 0;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_c0);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = idle; otherwise the cycle number since acceptance. Cycle 33 is the done cycle.
  int          m_cyc;
  logic [63:0] m_next;
  logic [63:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_prod <= '0;
      m_next <= '0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_cyc  <= 1;
        m_next <= 64'(multiplicand) * 64'(multiplier);
      end
    end else begin
      if (m_cyc == 32) m_prod <= m_next;
      m_cyc <= (m_cyc == 33) ? 0 : m_cyc + 1;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 64'(busy), 64'(m_cyc != 0));
      check("done", 64'(done), 64'(m_cyc == 33));
      check("product", product, m_prod);
      check("add_c0", 64'(add_c0), 64'd0);
      if (m_cyc == 0 || m_cyc == 33) check("add_b_idle", 64'(add_b), 64'd0);
    end
  end

  // Issues one multiply. It then waits (bounded) for done and checks latency and the literal result.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input string name);
    int lat;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_result"}, product, exp);
  endtask

  initial begin
    int d1, d2, i;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "mul_3x5");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_max");
    run_mul(32'd0, 32'h1234_5678, 64'd0, "mul_0xq");
    run_mul(32'h1234_5678, 32'd0, 64'd0, "mul_mx0");
    run_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "mul_carry");

    // Start held high. The operands change during the first run.
    @(negedge clk);
    multiplicand = 32'd1000;
    multiplier   = 32'd3;
    start        = 1'b1;
    d1 = -1;
    d2 = -1;
    for (i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (i == 3) begin
        multiplicand = 32'd9;
        multiplier   = 32'd9;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          check("held_first_result", product, 64'd3000);
        end else if (d2 < 0) begin
          d2 = i;
          check("held_second_result", product, 64'd81);
        end
      end
    end
    start = 1'b0;
    check("held_first_latency", 64'(d1), 64'd33);
    check("held_spacing", 64'(d2 - d1), 64'd34);
    i = 0;
    while (busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("held_drain", 64'(busy), 64'd0);

    // Reset during iteration 10 aborts the run.
    @(negedge clk);
    multiplicand = 32'h8000_0000;
    multiplier   = 32'd2;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_mul(32'd7, 32'd6, 64'd42, "mul_after_abort");

    // Random operands. The model checks every cycle, and a literal check compares the product with plain arithmetic.
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 10 == 0) ra = 32'hFFFF_FFFF;
      run_mul(ra, rb, 64'(ra) * 64'(rb), "rand");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
